// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants (default 640x480 @ 60 Hz) and coordinate helpers.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned DEF_HD = 640;
  localparam int unsigned DEF_HF = 16;
  localparam int unsigned DEF_HB = 48;
  localparam int unsigned DEF_HR = 96;
  localparam int unsigned DEF_VD = 480;
  localparam int unsigned DEF_VF = 10;
  localparam int unsigned DEF_VB = 33;
  localparam int unsigned DEF_VR = 2;

  localparam int unsigned HMAX        = DEF_HD + DEF_HF + DEF_HB + DEF_HR - 1;
  localparam int unsigned VMAX        = DEF_VD + DEF_VF + DEF_VB + DEF_VR - 1;
  localparam int unsigned HSYNC_START = DEF_HD + DEF_HF;
  localparam int unsigned HSYNC_END   = DEF_HD + DEF_HF + DEF_HR - 1;
  localparam int unsigned VSYNC_START = DEF_VD + DEF_VF;
  localparam int unsigned VSYNC_END   = DEF_VD + DEF_VF + DEF_VR - 1;

  function automatic coord_t wrap_inc(input coord_t v, input coord_t vmax);
    return (v == vmax) ? '0 : v + coord_t'(1);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle from the sync generator to the text/graphics consumers.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic   p_tick;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  coord_t pixel_x;
  coord_t pixel_y;
  logic   frame_start;

  modport master (
    output p_tick, hsync, vsync, video_on, pixel_x, pixel_y, frame_start
  );

  modport slave (
    input  p_tick, hsync, vsync, video_on, pixel_x, pixel_y, frame_start
  );

endinterface

// File: rtl/pixel_tick_div.sv
// Divides the system clock into a one-clk pixel tick every CLK_DIV clocks.
module pixel_tick_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic          r_tick;

  always_comb begin
    w_cnt_nx = (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
  end

  // Tick is registered from the next count so it lines up with div_cnt == CLK_DIV-1
  // and stays low while reset is held, even for CLK_DIV == 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nx;
      r_tick <= (w_cnt_nx == LAST);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel/line counters with zero-skew registered sync, video and frame strobes.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned HD      = DEF_HD,
  parameter int unsigned HF      = DEF_HF,
  parameter int unsigned HB      = DEF_HB,
  parameter int unsigned HR      = DEF_HR,
  parameter int unsigned VD      = DEF_VD,
  parameter int unsigned VF      = DEF_VF,
  parameter int unsigned VB      = DEF_VB,
  parameter int unsigned VR      = DEF_VR
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master o_vga
);

  localparam coord_t C_HMAX     = coord_t'(HD + HF + HB + HR - 1);
  localparam coord_t C_VMAX     = coord_t'(VD + VF + VB + VR - 1);
  localparam coord_t C_HD       = coord_t'(HD);
  localparam coord_t C_VD       = coord_t'(VD);
  localparam coord_t C_HS_START = coord_t'(HD + HF);
  localparam coord_t C_HS_END   = coord_t'(HD + HF + HR - 1);
  localparam coord_t C_VS_START = coord_t'(VD + VF);
  localparam coord_t C_VS_END   = coord_t'(VD + VF + VR - 1);

  logic   w_tick;
  coord_t r_x;
  coord_t r_y;
  coord_t w_nx;
  coord_t w_ny;
  logic   w_frame_wrap;
  logic   r_hsync;
  logic   r_vsync;
  logic   r_video_on;
  logic   r_frame_start;
  logic   r_rst_d;

  pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  always_comb begin
    w_nx         = r_x;
    w_ny         = r_y;
    w_frame_wrap = 1'b0;
    if (w_tick) begin
      w_nx = wrap_inc(r_x, C_HMAX);
      if (r_x == C_HMAX) begin
        w_ny         = wrap_inc(r_y, C_VMAX);
        w_frame_wrap = (r_y == C_VMAX);
      end
    end
  end

  // Sync/video decode the next-state coordinates so they register on the same edge
  // as the counters; r_rst_d marks the first clk after reset release for frame_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x           <= '0;
      r_y           <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_video_on    <= 1'b0;
      r_frame_start <= 1'b0;
      r_rst_d       <= 1'b1;
    end else begin
      r_x           <= w_nx;
      r_y           <= w_ny;
      r_hsync       <= !((w_nx >= C_HS_START) && (w_nx <= C_HS_END));
      r_vsync       <= !((w_ny >= C_VS_START) && (w_ny <= C_VS_END));
      r_video_on    <= (w_nx < C_HD) && (w_ny < C_VD);
      r_frame_start <= r_rst_d | w_frame_wrap;
      r_rst_d       <= 1'b0;
    end
  end

  assign o_vga.p_tick      = w_tick;
  assign o_vga.hsync       = r_hsync;
  assign o_vga.vsync       = r_vsync;
  assign o_vga.video_on    = r_video_on;
  assign o_vga.pixel_x     = r_x;
  assign o_vga.pixel_y     = r_y;
  assign o_vga.frame_start = r_frame_start;

endmodule
